store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer directly downstream of the single-cycle core's store port (MemWrite/DataAdr/WriteData).
- Queues up to DEPTH stores and drains them in order to data memory over a req/ack handshake.
- Stalls the core when full and forwards buffered store data to core loads on an address hit.
- Sits between the core's top-level memory bus and the data memory, replacing the direct write path.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 15, cycles in WAIT_ACK without mem_ack before a retry; >=1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- MemWrite  in  1  core store strobe.
- DataAdr  in  AW  core store address.
- WriteData  in  DW  core store data.
- Stall  out  1  core must hold its store; combinational = full & MemWrite.
- LoadAdr  in  AW  core load address for forwarding lookup.
- LoadHit  out  1  buffered store matches LoadAdr.
- LoadData  out  DW  data of the newest matching entry; 0 when no hit.
- mem_req  out  1  one-cycle request pulse to memory.
- mem_adr  out  AW  head entry address; valid while not empty.
- mem_wdata  out  DW  head entry data; valid while not empty.
- mem_ack  in  1  memory completion for the outstanding request.
- Empty  out  1  no entries queued.
- Count  out  $clog2(DEPTH)+1  entries queued.
- TimeoutErr  out  1  sticky; set on the first timeout, cleared only by reset.

Behaviour:
- Reset (async on reset=0):
  - count=0; head and tail pointers = 0; state=IDLE; timeout counter=0; TimeoutErr=0.
  - Outputs: Empty=1, Count=0, mem_req=0, Stall=0, LoadHit=0, LoadData=0.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Push at the edge when MemWrite & !full.
  - Pop at the edge when state==WAIT_ACK & mem_ack.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - full = (count==DEPTH), from registered state only. A pop in the same cycle does not clear Stall; the core retries next cycle.
- Drain FSM:
  - IDLE: mem_req=0. Go to ISSUE when count!=0 (registered count, so a store pushed at edge N gives ISSUE at N+1 and mem_req high during cycle N+1).
  - ISSUE: mem_req=1 for exactly one cycle; clear the timeout counter; go to WAIT_ACK unconditionally. mem_ack in ISSUE is ignored.
  - WAIT_ACK: on mem_ack, pop the head; go to ISSUE if count after pop !=0, else IDLE. Otherwise increment the timeout counter; when it reaches TIMEOUT, set TimeoutErr, go to ISSUE and re-send the same head entry (no pop).
  - mem_ack in IDLE is ignored.
- Forwarding (combinational):
  - Compare LoadAdr[AW-1:2] with every valid entry's address[AW-1:2].
  - The newest (closest to tail) match wins.
  - The head entry currently awaiting ack is still valid for matching.
  - An entry being pushed in the current cycle is not visible until the next cycle.
- Head stability: mem_adr and mem_wdata must not change between ISSUE and the ack; they change only on a pop.
- Reset mid-transaction: all entries are discarded, no further mem_req is issued, and a later mem_ack is ignored.
- Memory receives writes in strict arrival order; no merging or coalescing.

Test Plan:
- Reset, then a single store DataAdr=100, WriteData=7 → mem_req high exactly one cycle later with mem_adr=100, mem_wdata=7; mem_ack two cycles after that → Empty=1, state back to IDLE.
- Push stores to 96, 100, 104, 108 back to back with mem_ack held 0 → Count=4; a fifth MemWrite gives Stall=1 and no push; the first ack pops 96; the fifth store is accepted the following cycle.
- Stores 100←7, then 100←9, with ack withheld; LoadAdr=100 → LoadHit=1, LoadData=9. LoadAdr=102 (same word) → hit, data 9. LoadAdr=96 → LoadHit=0, LoadData=0.
- Single store 96←5 with ack withheld for TIMEOUT+2 cycles → TimeoutErr=1 and a second mem_req pulse with mem_adr=96; an ack then pops the entry, TimeoutErr stays 1.
- Buffer full (Count=4), MemWrite held high, pop and push attempt in the same cycle → Count=3 after the edge and no data lost. Separately, Count=2 with push and pop in the same cycle → Count stays 2, and the drain order matches the push order.
- Assert reset for one cycle while in WAIT_ACK with 3 entries → Empty=1, mem_req=0; a following stray mem_ack is ignored and Count stays 0.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write buffer between the core store port and data memory: in-order drain over
// req/ack with a retry on timeout, plus store-to-load forwarding from queued entries.
module store_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [AW-1:0]            DataAdr,
    input  logic [DW-1:0]            WriteData,
    output logic                     Stall,
    input  logic [AW-1:0]            LoadAdr,
    output logic                     LoadHit,
    output logic [DW-1:0]            LoadData,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_adr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     TimeoutErr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   adr_q  [DEPTH];
    logic [AW-1:0]   adr_d  [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [DW-1:0]   data_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            terr_q, terr_d;
    logic            full, push, pop;
    logic [PW-1:0]   fwd_idx;

    assign full  = (count_q == CW'(DEPTH));
    assign push  = MemWrite & ~full;
    assign pop   = (state_q == StWaitAck) & mem_ack;
    assign Stall = full & MemWrite;

    always_comb begin
        adr_d   = adr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (push) begin
            adr_d[tail_q]  = DataAdr;
            data_d[tail_q] = WriteData;
            tail_d         = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        terr_d  = terr_q;
        mem_req = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StIssue;
            end
            StIssue: begin
                mem_req = 1'b1;
                tmo_d   = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (mem_ack) begin
                    state_d = (count_d != '0) ? StIssue : StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    // Retry the same head entry; nothing is popped.
                    if (tmo_d == TW'(TIMEOUT)) begin
                        terr_d  = 1'b1;
                        state_d = StIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Walk oldest to newest so the newest matching entry is the one left standing.
    always_comb begin
        LoadHit  = 1'b0;
        LoadData = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (adr_q[fwd_idx][AW-1:2] == LoadAdr[AW-1:2])) begin
                LoadHit  = 1'b1;
                LoadData = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            tmo_q   <= '0;
            terr_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
            terr_q  <= terr_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
        end
    end

    assign mem_adr    = adr_q[head_q];
    assign mem_wdata  = data_q[head_q];
    assign Empty      = (count_q == '0);
    assign Count      = count_q;
    assign TimeoutErr = terr_q;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios then random traffic, all checked each cycle
// against a queue-based reference model of the posted-write buffer.
module tb_store_buffer;

    localparam int DEPTH   = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemWrite;
    logic [AW-1:0] DataAdr;
    logic [DW-1:0] WriteData;
    logic          Stall;
    logic [AW-1:0] LoadAdr;
    logic          LoadHit;
    logic [DW-1:0] LoadData;
    logic          mem_req;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic          Empty;
    logic [CW-1:0] Count;
    logic          TimeoutErr;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DW     (DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .Stall     (Stall),
        .LoadAdr   (LoadAdr),
        .LoadHit   (LoadHit),
        .LoadData  (LoadData),
        .mem_req   (mem_req),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .Empty     (Empty),
        .Count     (Count),
        .TimeoutErr(TimeoutErr)
    );

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } entry_t;

    // Reference: queued stores, whether a request is pending this cycle, whether one is
    // outstanding, and how long the outstanding one has waited.
    entry_t q[$];
    bit     req_now;
    bit     waiting;
    int     waited;
    bit     terr;
    int     n_vec;
    int     n_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input bit mw, input logic [AW-1:0] ladr);
        bit            hit = 1'b0;
        logic [DW-1:0] ld  = '0;
        foreach (q[i]) begin
            if (q[i].adr[AW-1:2] == ladr[AW-1:2]) begin
                hit = 1'b1;
                ld  = q[i].data;
            end
        end
        check_eq("Stall", Stall, (q.size() == DEPTH) && mw);
        check_eq("LoadHit", LoadHit, hit);
        check_eq("LoadData", LoadData, ld);
        check_eq("mem_req", mem_req, req_now);
        check_eq("Empty", Empty, q.size() == 0);
        check_eq("Count", Count, q.size());
        check_eq("TimeoutErr", TimeoutErr, terr);
        if (q.size() != 0) begin
            check_eq("mem_adr", mem_adr, q[0].adr);
            check_eq("mem_wdata", mem_wdata, q[0].data);
        end
    endtask

    task automatic step(input bit mw, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                        input logic [AW-1:0] ladr, input bit ack);
        bit was_full;
        bit had_entries;
        bit acked;
        @(negedge clk);
        MemWrite  = mw;
        DataAdr   = adr;
        WriteData = wd;
        LoadAdr   = ladr;
        mem_ack   = ack;
        #1 check_outputs(mw, ladr);
        @(posedge clk);
        was_full    = (q.size() == DEPTH);
        had_entries = (q.size() != 0);
        acked       = 1'b0;
        if (req_now) begin
            req_now = 1'b0;
            waiting = 1'b1;
            waited  = 0;
        end else if (waiting) begin
            if (ack) begin
                void'(q.pop_front());
                waiting = 1'b0;
                acked   = 1'b1;
            end else begin
                waited++;
                if (waited == TIMEOUT) begin
                    terr    = 1'b1;
                    waiting = 1'b0;
                    req_now = 1'b1;
                end
            end
        end else if (had_entries) begin
            req_now = 1'b1;
        end
        if (mw && !was_full) q.push_back('{adr: adr, data: wd});
        if (acked) req_now = (q.size() != 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        MemWrite = 1'b0;
        mem_ack  = 1'b0;
        q.delete();
        req_now  = 1'b0;
        waiting  = 1'b0;
        waited   = 0;
        terr     = 1'b0;
        #1 check_outputs(1'b0, LoadAdr);
        @(negedge clk);
        #1 check_outputs(1'b0, LoadAdr);
        reset = 1'b1;
    endtask

    function automatic logic [AW-1:0] rnd_adr();
        return 32'h40 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
    endfunction

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        LoadAdr   = '0;
        mem_ack   = 1'b0;
        do_reset();

        // Single store, ack two cycles after the request.
        step(1, 100, 7, 100, 0);
        step(0, 0, 0, 100, 0);
        step(0, 0, 0, 100, 0);
        step(0, 0, 0, 100, 0);
        step(0, 0, 0, 100, 1);
        step(0, 0, 0, 100, 0);

        // Fill, stall a fifth store, pop while it is held, then it is accepted.
        for (int a = 96; a <= 108; a += 4) step(1, a, a + 1, 104, 0);
        repeat (3) step(1, 200, 55, 108, 0);
        step(1, 200, 55, 200, 1);
        step(1, 200, 55, 200, 0);
        repeat (40) step(0, 0, 0, 200, $urandom_range(0, 1));

        // Forwarding: newest write to the same word wins.
        step(1, 100, 7, 100, 0);
        step(1, 100, 9, 100, 0);
        step(0, 0, 0, 100, 0);
        step(0, 0, 0, 102, 0);
        step(0, 0, 0, 96, 0);
        repeat (20) step(0, 0, 0, 100, 1);

        // Timeout and retry, then ack; error stays sticky.
        step(1, 96, 5, 96, 0);
        repeat (TIMEOUT + 4) step(0, 0, 0, 96, 0);
        repeat (4) step(0, 0, 0, 96, 1);
        repeat (3) step(0, 0, 0, 96, 0);

        // Reset while waiting on an ack with three entries; stray ack afterwards.
        step(1, 32, 1, 32, 0);
        step(1, 36, 2, 32, 0);
        step(1, 40, 3, 32, 0);
        step(0, 0, 0, 32, 0);
        do_reset();
        step(0, 0, 0, 32, 1);
        step(0, 0, 0, 32, 0);

        // Random traffic with varying memory responsiveness.
        for (int i = 0; i < 4000; i++) begin
            int ack_pct;
            ack_pct = ((i / 400) % 3 == 0) ? 30 : (((i / 400) % 3 == 1) ? 4 : 85);
            if (i == 2222) do_reset();
            step($urandom_range(0, 99) < 50, rnd_adr(), $urandom(), rnd_adr(),
                 $urandom_range(0, 99) < ack_pct);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
